// File: rtl/pong_match_controller.sv
// -----------------------------------------------------------------------------
// pong_match_controller
//
// Match-level sequencer for the Pong VGA design. Owns the game state machine
// (IDLE -> SERVE -> PLAY -> POINT -> SERVE/GAME_OVER), the serve delay, the
// per-rally speed-up and both player scores. All outputs are registered.
//
// Parameters:
//   WIN_SCORE        points needed to win a match (1..15)
//   SERVE_DELAY      frame ticks spent in SERVE before the ball moves (1..255)
//   HITS_PER_SPEEDUP paddle hits per speed increment (1..15)
//   MAX_SPEED        saturation value of o_Speed (1..3)
//
// Ports:
//   i_Clk          system clock
//   i_Reset        synchronous, active-high reset
//   i_Frame_Tick   one-cycle pulse per game update
//   i_Start        start switch (level); only its rising edge is used
//   i_Hit          one-cycle pulse on a paddle bounce
//   i_Miss_Left    one-cycle pulse when the ball leaves the left edge
//   i_Miss_Right   one-cycle pulse when the ball leaves the right edge
//   o_State        IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4
//   o_Ball_Enable  ball may move (PLAY only)
//   o_Ball_Center  hold ball at screen centre (every state but PLAY)
//   o_Serve_Dir    1 = serve toward right, 0 = toward left
//   o_Speed        ball step size, 1..MAX_SPEED
//   o_Score_Left   left player score
//   o_Score_Right  right player score
//   o_Game_Over    1 only in GAME_OVER
//   o_Winner       0 = left won, 1 = right won (valid with o_Game_Over)
// -----------------------------------------------------------------------------
module pong_match_controller #(
  parameter int WIN_SCORE        = 9,
  parameter int SERVE_DELAY      = 60,
  parameter int HITS_PER_SPEEDUP = 4,
  parameter int MAX_SPEED        = 3
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Frame_Tick,
  input  logic       i_Start,
  input  logic       i_Hit,
  input  logic       i_Miss_Left,
  input  logic       i_Miss_Right,
  output logic [2:0] o_State,
  output logic       o_Ball_Enable,
  output logic       o_Ball_Center,
  output logic       o_Serve_Dir,
  output logic [1:0] o_Speed,
  output logic [3:0] o_Score_Left,
  output logic [3:0] o_Score_Right,
  output logic       o_Game_Over,
  output logic       o_Winner
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    POINT     = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  // Parameters narrowed once to the widths of the registers they are compared against.
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_DELAY - 1);
  localparam logic [3:0] HIT_LAST   = 4'(HITS_PER_SPEEDUP - 1);
  localparam logic [1:0] SPEED_MAX  = 2'(MAX_SPEED);

  state_t     state;
  logic       start_q;
  logic       start_edge;
  logic [7:0] frame_cnt;
  logic [3:0] hit_cnt;

  assign start_edge = i_Start & ~start_q;
  assign o_State    = state;

  // NOTE: all state and outputs use non-blocking assignments so every branch
  // below reads the values held before this clock edge.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state         <= IDLE;
      // Reset to 1 so a switch already high during reset is not seen as an edge.
      start_q       <= 1'b1;
      frame_cnt     <= '0;
      hit_cnt       <= '0;
      o_Ball_Enable <= 1'b0;
      o_Ball_Center <= 1'b1;
      o_Serve_Dir   <= 1'b1;
      o_Speed       <= 2'd1;
      o_Score_Left  <= '0;
      o_Score_Right <= '0;
      o_Game_Over   <= 1'b0;
      o_Winner      <= 1'b0;
    end else begin
      start_q <= i_Start;

      case (state)
        IDLE: begin
          if (start_edge) begin
            state     <= SERVE;
            frame_cnt <= '0;
          end
        end

        SERVE: begin
          // Comparing against SERVE_DELAY-1 before the increment makes the
          // SERVE_DELAY-th tick the one that releases the ball.
          if (i_Frame_Tick) begin
            if (frame_cnt == SERVE_LAST) begin
              state         <= PLAY;
              o_Ball_Enable <= 1'b1;
              o_Ball_Center <= 1'b0;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end

        PLAY: begin
          // A miss takes priority over a simultaneous hit.
          if (i_Miss_Left || i_Miss_Right) begin
            state         <= POINT;
            o_Ball_Enable <= 1'b0;
            o_Ball_Center <= 1'b1;
            // Both edges missed in one cycle is a void rally: no score, same server.
            if (i_Miss_Left && !i_Miss_Right) begin
              o_Score_Right <= o_Score_Right + 4'd1;
              o_Serve_Dir   <= 1'b0;
            end else if (i_Miss_Right && !i_Miss_Left) begin
              o_Score_Left  <= o_Score_Left + 4'd1;
              o_Serve_Dir   <= 1'b1;
            end
          end else if (i_Hit) begin
            if (hit_cnt == HIT_LAST) begin
              hit_cnt <= '0;
              if (o_Speed != SPEED_MAX) begin
                o_Speed <= o_Speed + 2'd1;
              end
            end else begin
              hit_cnt <= hit_cnt + 4'd1;
            end
          end
        end

        POINT: begin
          if (o_Score_Left == WIN || o_Score_Right == WIN) begin
            state       <= GAME_OVER;
            o_Game_Over <= 1'b1;
            o_Winner    <= (o_Score_Left != WIN);
          end else begin
            state     <= SERVE;
            o_Speed   <= 2'd1;
            hit_cnt   <= '0;
            frame_cnt <= '0;
          end
        end

        GAME_OVER: begin
          if (start_edge) begin
            state         <= SERVE;
            o_Game_Over   <= 1'b0;
            o_Score_Left  <= '0;
            o_Score_Right <= '0;
            o_Speed       <= 2'd1;
            o_Serve_Dir   <= 1'b1;
            hit_cnt       <= '0;
            frame_cnt     <= '0;
          end
        end

        default: begin
          // Unused encodings fall back to IDLE with outputs consistent with it.
          state         <= IDLE;
          o_Ball_Enable <= 1'b0;
          o_Ball_Center <= 1'b1;
          o_Game_Over   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_match_controller.sv
// -----------------------------------------------------------------------------
// tb_pong_match_controller
//
// Self-checking bench for pong_match_controller with default parameters.
// Each driven cycle pushes the expected post-edge outputs onto a scoreboard
// queue; a monitor on the falling edge pops and compares them once the DUT
// has had its rising edge. Scenario tasks also make a few direct checks.
// -----------------------------------------------------------------------------
module tb_pong_match_controller;

  localparam logic [3:0] WIN = 4'd9;
  localparam int         SERVE_TICKS = 60;

  logic       i_Clk = 1'b0;
  logic       i_Reset = 1'b0;
  logic       i_Frame_Tick = 1'b0;
  logic       i_Start = 1'b0;
  logic       i_Hit = 1'b0;
  logic       i_Miss_Left = 1'b0;
  logic       i_Miss_Right = 1'b0;
  logic [2:0] o_State;
  logic       o_Ball_Enable;
  logic       o_Ball_Center;
  logic       o_Serve_Dir;
  logic [1:0] o_Speed;
  logic [3:0] o_Score_Left;
  logic [3:0] o_Score_Right;
  logic       o_Game_Over;
  logic       o_Winner;

  pong_match_controller dut (
    .i_Clk        (i_Clk),
    .i_Reset      (i_Reset),
    .i_Frame_Tick (i_Frame_Tick),
    .i_Start      (i_Start),
    .i_Hit        (i_Hit),
    .i_Miss_Left  (i_Miss_Left),
    .i_Miss_Right (i_Miss_Right),
    .o_State      (o_State),
    .o_Ball_Enable(o_Ball_Enable),
    .o_Ball_Center(o_Ball_Center),
    .o_Serve_Dir  (o_Serve_Dir),
    .o_Speed      (o_Speed),
    .o_Score_Left (o_Score_Left),
    .o_Score_Right(o_Score_Right),
    .o_Game_Over  (o_Game_Over),
    .o_Winner     (o_Winner)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    string      name;
    int         due;
    logic [2:0] st;
    logic       dir;
    logic [1:0] spd;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       win;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  // Expected outputs after the next rising edge; scenarios update these.
  logic [2:0] e_st  = 3'd0;
  logic       e_dir = 1'b1;
  logic [1:0] e_spd = 2'd1;
  logic [3:0] e_sl  = 4'd0;
  logic [3:0] e_sr  = 4'd0;
  logic       e_win = 1'b0;
  logic       start_lvl = 1'b1;

  always @(posedge i_Clk) cyc <= cyc + 1;

  // Scoreboard monitor.
  exp_t        m_e;
  logic [16:0] m_act;
  logic [16:0] m_req;
  always @(negedge i_Clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      m_e   = sb.pop_front();
      m_act = {o_State, o_Ball_Enable, o_Ball_Center, o_Serve_Dir, o_Speed,
               o_Score_Left, o_Score_Right, o_Game_Over};
      m_req = {m_e.st, (m_e.st == 3'd2), (m_e.st != 3'd2), m_e.dir, m_e.spd,
               m_e.sl, m_e.sr, (m_e.st == 3'd4)};
      total++;
      if (m_act !== m_req) begin
        bad++;
        $display("FAIL %s @cyc %0d: st/en/ctr/dir/spd/sl/sr/go got %h want %h",
                 m_e.name, cyc, m_act, m_req);
      end
      // Winner is defined after reset (IDLE) and in GAME_OVER.
      if (m_e.st == 3'd0 || m_e.st == 3'd4) begin
        total++;
        if (o_Winner !== m_e.win) begin
          bad++;
          $display("FAIL %s_winner @cyc %0d: got %b want %b", m_e.name, cyc, o_Winner, m_e.win);
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after its edge.
  task automatic drive(input string nm, input logic rst, input logic tick,
                       input logic hit, input logic ml, input logic mr);
    exp_t e;
    @(negedge i_Clk);
    i_Reset      = rst;
    i_Frame_Tick = tick;
    i_Hit        = hit;
    i_Miss_Left  = ml;
    i_Miss_Right = mr;
    i_Start      = start_lvl;
    e.name = nm;
    e.due  = cyc + 1;
    e.st   = e_st;
    e.dir  = e_dir;
    e.spd  = e_spd;
    e.sl   = e_sl;
    e.sr   = e_sr;
    e.win  = e_win;
    sb.push_back(e);
  endtask

  task automatic set_reset_expect();
    e_st = 3'd0; e_dir = 1'b1; e_spd = 2'd1; e_sl = 4'd0; e_sr = 4'd0; e_win = 1'b0;
  endtask

  // From freshly entered SERVE: SERVE_TICKS ticks, PLAY after the last.
  task automatic serve_to_play();
    for (int i = 1; i <= SERVE_TICKS; i++) begin
      e_st = (i == SERVE_TICKS) ? 3'd2 : 3'd1;
      drive("serve_tick", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // One full rally ending with the given miss, then the cycle after POINT.
  task automatic rally(input logic ml, input logic mr);
    serve_to_play();
    e_st = 3'd3;
    if (ml && !mr) begin e_sr = e_sr + 4'd1; e_dir = 1'b0; end
    if (mr && !ml) begin e_sl = e_sl + 4'd1; e_dir = 1'b1; end
    drive("rally_miss", 1'b0, 1'b0, 1'b0, ml, mr);
    if (e_sl == WIN || e_sr == WIN) begin
      e_st  = 3'd4;
      e_win = (e_sl == WIN) ? 1'b0 : 1'b1;
    end else begin
      e_st  = 3'd1;
      e_spd = 2'd1;
    end
    drive("rally_after_point", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    start_lvl = 1'b1;
    set_reset_expect();
    for (int i = 0; i < 3; i++) drive("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive("start_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (o_State !== 3'd0) begin
      bad++;
      $display("FAIL start_held_idle: state %0d want 0", o_State);
    end
    start_lvl = 1'b0;
    drive("start_low", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start_lvl = 1'b1;
    e_st = 3'd1;
    drive("start_edge", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("serve_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (o_State !== 3'd1 || o_Serve_Dir !== 1'b1) begin
      bad++;
      $display("FAIL start_to_serve: state %0d dir %b want 1 1", o_State, o_Serve_Dir);
    end
  endtask

  task automatic test_serve_delay();
    // Start edge in SERVE is ignored and non-tick cycles do not count.
    start_lvl = 1'b0;
    drive("serve_start_low", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start_lvl = 1'b1;
    drive("serve_start_edge", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= SERVE_TICKS; i++) begin
      e_st = (i == SERVE_TICKS) ? 3'd2 : 3'd1;
      // Hit and both misses on tick 10 must be ignored in SERVE.
      drive("serve_delay", 1'b0, 1'b1, (i == 10), (i == 10), (i == 10));
    end
    drive("play_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (o_Ball_Enable !== 1'b1 || o_Ball_Center !== 1'b0) begin
      bad++;
      $display("FAIL play_ball_ctrl: en %b ctr %b want 1 0", o_Ball_Enable, o_Ball_Center);
    end
  endtask

  task automatic test_speedup();
    for (int i = 1; i <= 12; i++) begin
      e_spd = (i >= 8) ? 2'd3 : (i >= 4) ? 2'd2 : 2'd1;
      drive("speed_hit", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    e_st = 3'd3; e_sl = 4'd1; e_dir = 1'b1;
    drive("speed_miss_right", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    e_st = 3'd1; e_spd = 2'd1;
    drive("speed_point_serve", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (o_State !== 3'd3 || o_Speed !== 2'd3) begin
      bad++;
      $display("FAIL speed_point: state %0d speed %0d want 3 3", o_State, o_Speed);
    end
  endtask

  task automatic test_scoring();
    serve_to_play();
    // Miss and hit together: the miss wins.
    e_st = 3'd3; e_sr = 4'd1; e_dir = 1'b0;
    drive("miss_left_hit", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    e_st = 3'd1;
    drive("score_point_serve", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (o_State !== 3'd3 || o_Score_Right !== 4'd1) begin
      bad++;
      $display("FAIL score_point: state %0d right %0d want 3 1", o_State, o_Score_Right);
    end
    serve_to_play();
    // Start edge in PLAY is ignored.
    start_lvl = 1'b0;
    drive("play_start_low", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start_lvl = 1'b1;
    drive("play_start_edge", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_st = 3'd3;
    drive("double_miss", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    e_st = 3'd1;
    drive("double_point_serve", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_match_end();
    for (int r = 0; r < 8; r++) rally(1'b0, 1'b1);
    // GAME_OVER ignores ticks, hits and misses.
    drive("go_tick", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive("go_miss_left", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive("go_miss_right", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive("go_hit", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (o_Game_Over !== 1'b1 || o_Winner !== 1'b0 || o_Score_Left !== WIN) begin
      bad++;
      $display("FAIL left_win: go %b winner %b left %0d want 1 0 9",
               o_Game_Over, o_Winner, o_Score_Left);
    end
    start_lvl = 1'b0;
    drive("go_start_low", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start_lvl = 1'b1;
    e_st = 3'd1; e_sl = 4'd0; e_sr = 4'd0; e_spd = 2'd1; e_dir = 1'b1;
    drive("go_restart", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("restart_serve", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_right_wins();
    for (int r = 0; r < 9; r++) rally(1'b1, 1'b0);
    drive("go_right_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (o_Winner !== 1'b1 || o_Score_Right !== WIN) begin
      bad++;
      $display("FAIL right_win: winner %b right %0d want 1 9", o_Winner, o_Score_Right);
    end
    start_lvl = 1'b0;
    drive("go_start_low2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start_lvl = 1'b1;
    e_st = 3'd1; e_sl = 4'd0; e_sr = 4'd0; e_spd = 2'd1; e_dir = 1'b1;
    drive("go_restart2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_rally();
    for (int r = 0; r < 3; r++) rally(1'b0, 1'b1);
    for (int r = 0; r < 5; r++) rally(1'b1, 1'b0);
    serve_to_play();
    for (int i = 1; i <= 4; i++) begin
      e_spd = (i == 4) ? 2'd2 : 2'd1;
      drive("mid_hit", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    drive("mid_play", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (o_Score_Left !== 4'd3 || o_Score_Right !== 4'd5 || o_Speed !== 2'd2) begin
      bad++;
      $display("FAIL mid_setup: left %0d right %0d speed %0d want 3 5 2",
               o_Score_Left, o_Score_Right, o_Speed);
    end
    set_reset_expect();
    drive("reset_mid_rally", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("after_reset2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_serve_delay();
    test_speedup();
    test_scoring();
    test_match_end();
    test_right_wins();
    test_reset_mid_rally();
    // Let the monitor retire the last queued expectations.
    @(negedge i_Clk);
    @(negedge i_Clk);
    @(negedge i_Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
